// File: rtl/seg_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver_if
// Description : Processor IO bus plus display pins of the 7-segment scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface seg_scan_driver_if;
    logic        IOWriteEn;
    logic [3:0]  IOAddr;
    logic [31:0] IOWriteData;
    logic [31:0] IORdData;
    logic [3:0]  AN;
    logic [6:0]  LED;

    modport master (
        output IOWriteEn, IOAddr, IOWriteData,
        input  IORdData, AN, LED
    );

    modport slave (
        input  IOWriteEn, IOAddr, IOWriteData,
        output IORdData, AN, LED
    );
endinterface
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Four-digit multiplexed hex display driver with IO-mapped
//               VALUE/CTRL registers. Optional macro SEG_BLANK_LEADING_ZERO_EN
//               compiles in leading-zero blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int REFRESH_BITS = 16
) (
    input  wire logic         CLK,
    input  wire logic         RESET,
    seg_scan_driver_if.slave  bus
);

    localparam logic [15:0] c_VALUE_RST = 16'h0000;
    localparam logic [7:0]  c_CTRL_RST  = 8'h01;
    localparam logic [3:0]  c_AN_OFF    = 4'b1111;
    localparam logic [6:0]  c_LED_OFF   = 7'b1111111;

    logic [REFRESH_BITS-1:0] r_cnt;
    logic [15:0]             r_value;
    logic [7:0]              r_ctrl;
    logic [1:0]              r_prev_sel;
    logic [3:0]              r_an;
    logic [6:0]              r_led;

    logic                    w_wr_value;
    logic                    w_wr_ctrl;
    logic [15:0]             w_value_nxt;
    logic [7:0]              w_ctrl_nxt;
    logic [1:0]              w_sel;
    logic [3:0]              w_nibble;
    logic [6:0]              w_seg;
    logic                    w_lz_blank;
    logic                    w_mask_blank;
    logic [3:0]              w_an_nxt;
    logic [6:0]              w_led_nxt;
    logic                    w_unused;

    assign w_wr_value = bus.IOWriteEn && (bus.IOAddr == 4'h0);
    assign w_wr_ctrl  = bus.IOWriteEn && (bus.IOAddr == 4'h1);

    // Display decode uses post-write register values so a coincident write wins.
    assign w_value_nxt = w_wr_value ? bus.IOWriteData[15:0] : r_value;
    assign w_ctrl_nxt  = w_wr_ctrl  ? bus.IOWriteData[7:0]  : r_ctrl;

    assign w_sel        = r_cnt[REFRESH_BITS-1 -: 2];
    assign w_nibble     = w_value_nxt[{w_sel, 2'b00} +: 4];
    assign w_mask_blank = w_ctrl_nxt[3'd4 + {1'b0, w_sel}];
    assign w_unused     = &{1'b0, bus.IOWriteData[31:16]};

`ifdef SEG_BLANK_LEADING_ZERO_EN
    always_comb begin
        w_lz_blank = 1'b0;
        case (w_sel)
            2'd1:    w_lz_blank = (w_value_nxt[15:4]  == 12'h000);
            2'd2:    w_lz_blank = (w_value_nxt[15:8]  == 8'h00);
            2'd3:    w_lz_blank = (w_value_nxt[15:12] == 4'h0);
            default: w_lz_blank = 1'b0;
        endcase
    end
`else
    assign w_lz_blank = 1'b0;
`endif

    // Active-low {g,f,e,d,c,b,a}
    always_comb begin
        w_seg = c_LED_OFF;
        case (w_nibble)
            4'h0:    w_seg = 7'b1000000;
            4'h1:    w_seg = 7'b1111001;
            4'h2:    w_seg = 7'b0100100;
            4'h3:    w_seg = 7'b0110000;
            4'h4:    w_seg = 7'b0011001;
            4'h5:    w_seg = 7'b0010010;
            4'h6:    w_seg = 7'b0000010;
            4'h7:    w_seg = 7'b1111000;
            4'h8:    w_seg = 7'b0000000;
            4'h9:    w_seg = 7'b0010000;
            4'hA:    w_seg = 7'b0001000;
            4'hB:    w_seg = 7'b0000011;
            4'hC:    w_seg = 7'b1000110;
            4'hD:    w_seg = 7'b0100001;
            4'hE:    w_seg = 7'b0000110;
            default: w_seg = 7'b0001110;
        endcase
    end

    // A digit change forces one dark cycle so the old segments never ghost.
    always_comb begin
        w_an_nxt  = c_AN_OFF;
        w_led_nxt = c_LED_OFF;
        if (w_ctrl_nxt[0] && (w_sel == r_prev_sel)) begin
            w_an_nxt = ~(4'b0001 << w_sel);
            if (!w_mask_blank && !w_lz_blank) begin
                w_led_nxt = w_seg;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_value    <= c_VALUE_RST;
            r_ctrl     <= c_CTRL_RST;
            r_prev_sel <= 2'd0;
            r_an       <= c_AN_OFF;
            r_led      <= c_LED_OFF;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_value    <= w_value_nxt;
            r_ctrl     <= w_ctrl_nxt;
            r_prev_sel <= w_sel;
            r_an       <= w_an_nxt;
            r_led      <= w_led_nxt;
        end
    end

    always_comb begin
        bus.IORdData = 32'h0000_0000;
        case (bus.IOAddr)
            4'h0:    bus.IORdData = {16'h0000, r_value};
            4'h1:    bus.IORdData = {24'h000000, r_ctrl};
            default: bus.IORdData = 32'h0000_0000;
        endcase
    end

    assign bus.AN  = r_an;
    assign bus.LED = r_led;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_driver
// Description : Scoreboard bench for seg_scan_driver with REFRESH_BITS = 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    typedef struct {
        int          pe;
        bit          is_rd;
        logic [3:0]  an;
        logic [6:0]  led;
        bit          chk_led;
        logic [31:0] rd;
        string       name;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    int   pe;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seg_scan_driver_if bus();

    seg_scan_driver #(.REFRESH_BITS(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Rising edges since the last reset release; output after edge p shows counter p-1.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) pe <= 0;
        else       pe <= pe + 1;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic void push_out(input int p, input logic [3:0] an,
                                     input logic [6:0] led, input bit chk, input string nm);
        exp_t e;
        e.pe = p; e.is_rd = 1'b0; e.an = an; e.led = led; e.chk_led = chk;
        e.rd = '0; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic void push_rd(input int p, input logic [31:0] d, input string nm);
        exp_t e;
        e.pe = p; e.is_rd = 1'b1; e.an = '0; e.led = '0; e.chk_led = 1'b0;
        e.rd = d; e.name = nm;
        sb.push_back(e);
    endfunction

    function automatic void push_scan(input int pfrom, input int cnt, input logic [15:0] v,
                                      input logic [7:0] c, input string nm);
        int         n;
        int         sel;
        bit         blank;
        logic [3:0] an;
        logic [15:0] hi;
        for (int p = pfrom; p < pfrom + cnt; p++) begin
            n   = p - 1;
            sel = (n % 16) / 4;
            if (!c[0]) begin
                push_out(p, 4'b1111, 7'b1111111, 1'b1, nm);
            end else if ((n % 4 == 0) && (n > 0)) begin
                push_out(p, 4'b1111, 7'b1111111, 1'b0, {nm, "_gap"});
            end else begin
                an    = ~(4'b0001 << sel);
                blank = c[4 + sel];
`ifdef SEG_BLANK_LEADING_ZERO_EN
                hi = v >> (4 * sel);
                if (sel >= 1 && hi == 16'h0000) blank = 1'b1;
`else
                hi = 16'h0000;
`endif
                push_out(p, an, blank ? 7'b1111111 : seg_of(v[sel*4 +: 4]), 1'b1, nm);
            end
        end
    endfunction

    always @(negedge CLK) begin : monitor
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].pe == pe) begin
                n_cmp++;
                if (sb[i].is_rd) begin
                    if (bus.IORdData !== sb[i].rd) begin
                        n_fail++;
                        $display("FAIL %s pe=%0d: IORdData got %h want %h",
                                 sb[i].name, pe, bus.IORdData, sb[i].rd);
                    end
                end else if (bus.AN !== sb[i].an || (sb[i].chk_led && bus.LED !== sb[i].led)) begin
                    n_fail++;
                    $display("FAIL %s pe=%0d: AN/LED got %b/%b want %b/%b",
                             sb[i].name, pe, bus.AN, bus.LED, sb[i].an, sb[i].led);
                end
                sb.delete(i);
            end else if (sb[i].pe < pe) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s: check for pe=%0d missed (now %0d), got none want sample",
                         sb[i].name, sb[i].pe, pe);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic wait_pe(input int target);
        do @(negedge CLK); while (pe < target);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.IOWriteEn   = 1'b1;
        bus.IOAddr      = a;
        bus.IOWriteData = d;
        @(posedge CLK);
        #1;
        bus.IOWriteEn   = 1'b0;
    endtask

    initial begin : watchdog
        #50000;
        n_fail++;
        $display("FAIL watchdog: got timeout want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : stim
        RESET           = 1'b1;
        bus.IOWriteEn   = 1'b1;
        bus.IOAddr      = 4'h1;
        bus.IOWriteData = 32'h0000_0000;
        // Writes held during reset must be discarded.
        push_out(0, 4'b1111, 7'b1111111, 1'b1, "rst_out");
        push_rd(0, 32'h0000_0001, "rst_ctrl");
        @(negedge CLK); #1;
        bus.IOAddr      = 4'h0;
        bus.IOWriteData = 32'h0000_BEEF;
        push_rd(0, 32'h0000_0000, "rst_value");
        @(negedge CLK); #1;

        RESET = 1'b0;
        push_rd(1, 32'h0000_1A2F, "rd_value");
        push_scan(1, 16, 16'h1A2F, 8'h01, "scan_1A2F");
        wr(4'h0, 32'h0000_1A2F);

        wait_pe(16);
        push_rd(17, 32'h0000_0021, "rd_ctrl");
        push_scan(17, 16, 16'h1A2F, 8'h21, "mask_d1");
        wr(4'h1, 32'h0000_0021);

        wait_pe(32);
        push_rd(33, 32'h0000_0000, "rd_unmapped");
        push_scan(33, 8, 16'h1A2F, 8'h21, "unmapped_wr");
        wr(4'h7, 32'h0000_DEAD);
        wait_pe(33);
        bus.IOAddr = 4'h0;
        push_rd(34, 32'h0000_1A2F, "value_kept");
        wait_pe(34);
        bus.IOAddr = 4'h1;
        push_rd(35, 32'h0000_0021, "ctrl_kept");

        wait_pe(40);
        push_scan(41, 16, 16'h1A2F, 8'h00, "disabled");
        wr(4'h1, 32'h0000_0000);

        wait_pe(56);
        push_scan(57, 7, 16'h1A2F, 8'h01, "reenable");
        wr(4'h1, 32'h0000_0001);

        // Counter wraps to 0 on edge 64: the write lands on that same edge.
        wait_pe(63);
        push_scan(64, 8, 16'h0008, 8'h01, "collision");
        wr(4'h0, 32'h0000_0008);

        wait_pe(71);
        push_scan(72, 16, 16'h0050, 8'h01, "lz_0050");
        wr(4'h0, 32'h0000_0050);

        wait_pe(87);
        push_scan(88, 16, 16'h0000, 8'h01, "lz_0000");
        wr(4'h0, 32'h0000_0000);

        wait_pe(103);
        wr(4'h0, 32'h0000_1234);
        wr(4'h1, 32'h0000_0031);
        bus.IOAddr = 4'h1;
        @(posedge CLK); #1;
        RESET = 1'b1;
        push_out(0, 4'b1111, 7'b1111111, 1'b1, "midrst_out");
        push_rd(0, 32'h0000_0001, "midrst_ctrl");
        @(negedge CLK); #1;
        bus.IOAddr = 4'h0;
        push_rd(0, 32'h0000_0000, "midrst_value");
        @(negedge CLK); #1;
        RESET = 1'b0;
        push_scan(1, 4, 16'h0000, 8'h01, "post_rst");
        wait_pe(5);

        while (sb.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: pending check pe=%0d got none want sample", sb[0].name, sb[0].pe);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 16, giving the refresh counter width (min 3); the top 2 bits select the digit.
REQ-002 SHALL have port CLK  input  1  system clock (10 MHz divided clock); all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port IOWriteEn  input  1  processor IO write strobe, one cycle per write.
REQ-005 SHALL have port IOAddr  input  4  processor IO register address.
REQ-006 SHALL have port IOWriteData  input  32  processor IO write data.
REQ-007 SHALL have port IORdData  output  32  combinational readback of the addressed register.
REQ-008 SHALL have port AN  output  4  digit anodes, active-low, registered.
REQ-009 SHALL have port LED  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.

Function
REQ-010 SHALL implement register VALUE at IOAddr 4'h0: 16 bits, four hex digits, digit 0 = VALUE[3:0]; write loads IOWriteData[15:0].
REQ-011 SHALL implement register CTRL at IOAddr 4'h1: bit0 = display enable, bits[7:4] = per-digit blank mask (1 = blank digit n); write loads IOWriteData[7:0].
REQ-012 SHALL ignore writes to IOAddr 4'h2-4'hF; no state changes.
REQ-013 SHALL drive IORdData = {16'b0,VALUE} at 4'h0, {24'b0,CTRL} at 4'h1, 32'b0 otherwise, independent of IOWriteEn.
REQ-014 SHALL increment the refresh counter by 1 every cycle, wrapping from all-ones to 0.
REQ-015 SHALL take digit index sel = counter[REFRESH_BITS-1:REFRESH_BITS-2]; sel 0..3 drives AN = 1110, 1101, 1011, 0111 respectively.
REQ-016 SHALL register AN/LED from the current sel, VALUE and CTRL: outputs reflect state one cycle later (1-cycle latency).
REQ-017 SHALL drive AN = 4'b1111 for exactly one cycle whenever sel changes (anti-ghosting gap), then the new digit's anode.
REQ-018 SHALL decode hex 0-F to the standard active-low patterns (0 = 1000000, 1 = 1111001, 8 = 0000000, A = 0001000, F = 0001110).
REQ-019 SHALL drive LED = 7'b1111111 for a digit blanked by mask or by REQ-027; AN still follows the scan.
REQ-020 SHALL drive AN = 4'b1111 and LED = 7'b1111111 while CTRL[0] = 0; the counter keeps running.
REQ-021 SHALL, on a write on the same edge a digit is sampled, display the new value from the following cycle onward (write wins, no torn digit).

Reset
REQ-022 SHALL, while RESET is high, asynchronously force counter = 0, VALUE = 16'h0000, CTRL = 8'h01, AN = 4'b1111, LED = 7'b1111111.
REQ-023 SHALL, on the first edge after RESET deasserts, count from 0 with sel = 0; the first anode (1110) appears no later than 2 cycles after release.
REQ-024 SHALL discard a write coincident with RESET high.

Configuration
REQ-025 SHALL compile leading-zero blanking in only when macro SEG_BLANK_LEADING_ZERO_EN is defined.
REQ-026 SHALL, without the macro, show all four digits including leading zeros (subject to the mask).
REQ-027 SHALL, with the macro, blank each digit n >= 1 whose VALUE nibble and all higher nibbles are zero; digit 0 is never blanked by this rule.

Verification (bench uses REFRESH_BITS = 4)
REQ-028 SHALL check reset: RESET pulse mid-scan -> AN = 1111, LED = 1111111 immediately; IORdData at 4'h1 = 32'h00000001.
REQ-029 SHALL check scan: write VALUE = 16'h1A2F -> over one 16-cycle scan, the digits show F, 2, A, 1 (LED 0001110, 0100100, 0001000, 1111001), with a one-cycle AN = 1111 gap at each sel change.
REQ-030 SHALL check masking and enable: write CTRL = 8'h21 -> digit 1 shows LED 1111111 and the other digits are normal; write CTRL = 8'h00 -> AN stays 1111 for a full scan.
REQ-031 SHALL check address decode: write 32'hDEAD to IOAddr 4'h7 -> VALUE and CTRL are unchanged; IORdData at 4'h7 = 0.
REQ-032 SHALL check leading-zero blanking: with the macro defined and VALUE = 16'h0050, digits 3 and 2 are blank while digits 1 and 0 show 5 and 0; with VALUE = 16'h0000, only digit 0 shows 0.
REQ-033 SHALL check collision: write VALUE = 16'h0008 on the edge sel enters 0 -> digit 0 shows 0000000 on its first lit cycle.
